fpu_seq: RTL and testbench

FPU_SEQ -- requirements
Module: fpu_seq

---
 rtl/fpu_pkg.sv | 42 ++++
 rtl/fpu_lzc.sv | 18 +
 rtl/fpu_seq.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_fpu_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared opcodes, FSM encoding and operand classes for the sequential FPU.
package fpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_RCPA = 3'b100;
    localparam logic [2:0] OP_RCPB = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_EXEC,
        ST_NORM,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } cls_t;

    // Datapath flavour chosen at acceptance; reciprocals reuse the divider.
    typedef enum logic [1:0] {
        K_ADD,
        K_MUL,
        K_DIV,
        K_BAD
    } kind_t;

    // Subnormals (exponent zero) are classified as zero.
    function automatic cls_t classify(input logic exp_zero, input logic exp_ones,
                                      input logic man_zero);
        if (exp_zero) return CLS_ZERO;
        if (exp_ones) return man_zero ? CLS_INF : CLS_NAN;
        return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; returns W for an all-zero input.
module fpu_lzc #(
    parameter int unsigned W  = 48,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count_c
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        count_c = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count_c = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_seq.sv
// Multi-cycle IEEE-style FPU: add/sub, shift-add multiply, restoring divide,
// reciprocal; truncating rounding, flush-to-zero, valid/ready on both sides.
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    input  logic [2:0]           OpCode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] Result,
    output logic                 Overflow_out,
    output logic                 Underflow_out,
    output logic                 Invalid_out
);

    localparam int unsigned WIDTH = 1 + EXP_W + MAN_W;
    localparam int unsigned MW    = MAN_W + 1;
    localparam int unsigned QW    = MAN_W + 3;
    localparam int unsigned SW    = MAN_W + 5;
    localparam int unsigned NW    = 2 * MW;
    localparam int unsigned LZW   = $clog2(NW + 1);
    localparam int unsigned EW    = EXP_W + LZW + 2;
    localparam int unsigned CNTW  = $clog2(QW);
    localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX  = (1 << EXP_W) - 1;
    localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_S  = EW'(EMAX);
    localparam logic [WIDTH-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [WIDTH-1:0]     ONE     = {2'b00, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};
    localparam logic [WIDTH-2:0]     MAG_INF = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    state_t                 state, state_next;
    kind_t                  kind_q;
    logic [WIDTH-1:0]       x_q, y_q;
    logic                   sgn_q;
    logic signed [EW-1:0]   exp_q;
    logic [NW-1:0]          val_q, prod_q;
    logic [MW:0]            rem_q;
    logic [QW-1:0]          quo_q;
    logic [CNTW-1:0]        cnt_q;
    logic                   in_ready_d, out_valid_d;

    logic                   sx, sy;
    logic [EXP_W-1:0]       ex, ey;
    logic [MAN_W-1:0]       fx, fy;
    logic [MW-1:0]          mx, my;
    logic signed [EW-1:0]   exs, eys;
    cls_t                   cx, cy;

    assign {sx, ex, fx} = x_q;
    assign {sy, ey, fy} = y_q;
    assign mx  = {1'b1, fx};
    assign my  = {1'b1, fy};
    assign exs = EW'(ex);
    assign eys = EW'(ey);
    assign cx  = classify(ex == '0, &ex, fx == '0);
    assign cy  = classify(ey == '0, &ey, fy == '0);

    // Special-operand resolution, decided in UNPACK.
    logic             spec, spec_inv;
    logic [WIDTH-1:0] spec_res;
    always_comb begin
        spec     = 1'b1;
        spec_inv = 1'b0;
        spec_res = QNAN;
        if (kind_q == K_BAD || cx == CLS_NAN || cy == CLS_NAN) begin
            spec_inv = 1'b1;
        end else begin
            case (kind_q)
                K_ADD: begin
                    if (cx == CLS_INF && cy == CLS_INF) begin
                        if (sx != sy) spec_inv = 1'b1;
                        else          spec_res = {sx, MAG_INF};
                    end
                    else if (cx == CLS_INF)                     spec_res = {sx, MAG_INF};
                    else if (cy == CLS_INF)                     spec_res = {sy, MAG_INF};
                    else if (cx == CLS_ZERO && cy == CLS_ZERO)  spec_res = {sx & sy, {(WIDTH-1){1'b0}}};
                    else if (cx == CLS_ZERO)                    spec_res = y_q;
                    else if (cy == CLS_ZERO)                    spec_res = x_q;
                    else                                        spec     = 1'b0;
                end
                K_MUL: begin
                    if ((cx == CLS_ZERO && cy == CLS_INF) || (cx == CLS_INF && cy == CLS_ZERO))
                        spec_inv = 1'b1;
                    else if (cx == CLS_INF || cy == CLS_INF)    spec_res = {sx ^ sy, MAG_INF};
                    else if (cx == CLS_ZERO || cy == CLS_ZERO)  spec_res = {sx ^ sy, {(WIDTH-1){1'b0}}};
                    else                                        spec     = 1'b0;
                end
                default: begin
                    if ((cx == CLS_ZERO && cy == CLS_ZERO) || (cx == CLS_INF && cy == CLS_INF))
                        spec_inv = 1'b1;
                    else if (cx == CLS_INF || cy == CLS_ZERO)   spec_res = {sx ^ sy, MAG_INF};
                    else if (cx == CLS_ZERO || cy == CLS_INF)   spec_res = {sx ^ sy, {(WIDTH-1){1'b0}}};
                    else                                        spec     = 1'b0;
                end
            endcase
        end
    end

    // Align and add; a sticky borrow keeps truncated subtraction toward zero.
    logic                 x_big, add_sgn, sticky;
    logic [EXP_W-1:0]     d;
    logic signed [EW-1:0] add_exp;
    logic [SW-1:0]        big_e, small_pre, small_sh, add_sum;
    always_comb begin
        x_big     = x_q[WIDTH-2:0] >= y_q[WIDTH-2:0];
        add_sgn   = x_big ? sx : sy;
        add_exp   = (x_big ? exs : eys) + EW'(1);
        d         = x_big ? ex - ey : ey - ex;
        big_e     = {1'b0, (x_big ? mx : my), 3'b000};
        small_pre = {1'b0, (x_big ? my : mx), 3'b000};
        small_sh  = small_pre >> d;
        sticky    = |(small_pre & ~({SW{1'b1}} << d));
        add_sum   = (sx ^ sy) ? big_e - small_sh - SW'(sticky) : big_e + small_sh;
    end

    // One shift-add multiply step and one restoring divide step per EXEC cycle.
    logic [MW:0]   mul_sum, rdiff, rem_next;
    logic [NW-1:0] prod_next;
    logic [QW-1:0] quo_next;
    logic          ge, exec_last;
    always_comb begin
        mul_sum   = (MW+1)'(prod_q[NW-1:MW]) + (MW+1)'(mx & {MW{prod_q[0]}});
        prod_next = {mul_sum, prod_q[MW-1:1]};
        ge        = rem_q >= {1'b0, my};
        rdiff     = ge ? rem_q - {1'b0, my} : rem_q;
        rem_next  = (MW+1)'({rdiff, 1'b0});
        quo_next  = QW'({quo_q, ge});
        case (kind_q)
            K_MUL:   exec_last = (cnt_q == CNTW'(MW - 1));
            K_DIV:   exec_last = (cnt_q == CNTW'(QW - 1));
            default: exec_last = 1'b1;
        endcase
    end

    // Normalise: exp_q is the biased exponent of val_q's top bit.
    logic [LZW-1:0]       lz;
    logic signed [EW-1:0] e_n;
    logic [MAN_W-1:0]     norm_frac;
    logic [WIDTH-1:0]     norm_res;
    logic                 norm_ovf, norm_unf;

    fpu_lzc #(.W(NW), .CW(LZW)) u_lzc (
        .value   (val_q),
        .count_c (lz)
    );

    always_comb begin
        e_n       = exp_q - $signed(EW'(lz));
        norm_frac = MAN_W'((val_q << lz) >> (NW - 1 - MAN_W));
        norm_res  = {sgn_q, e_n[EXP_W-1:0], norm_frac};
        norm_ovf  = 1'b0;
        norm_unf  = 1'b0;
        if (lz == LZW'(NW)) begin
            norm_res = '0;
        end else if (e_n >= EMAX_S) begin
            norm_res = {sgn_q, MAG_INF};
            norm_ovf = 1'b1;
        end else if (e_n <= EW'(0)) begin
            norm_res = {sgn_q, {(WIDTH-1){1'b0}}};
            norm_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (in_valid && in_ready) state_next = ST_UNPACK;
            ST_UNPACK: state_next = spec ? ST_DONE : ST_EXEC;
            ST_EXEC:   if (exec_last) state_next = ST_NORM;
            ST_NORM:   state_next = ST_DONE;
            ST_DONE:   if (out_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        if (state_next == ST_IDLE) in_ready_d  = 1'b1;
        if (state_next == ST_DONE) out_valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_q        <= K_ADD;
            x_q           <= '0;
            y_q           <= '0;
            sgn_q         <= 1'b0;
            exp_q         <= '0;
            val_q         <= '0;
            prod_q        <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            cnt_q         <= '0;
            Result        <= '0;
            Overflow_out  <= 1'b0;
            Underflow_out <= 1'b0;
            Invalid_out   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid && in_ready) begin
                    case (OpCode)
                        OP_ADD, OP_SUB:          kind_q <= K_ADD;
                        OP_MUL:                  kind_q <= K_MUL;
                        OP_DIV, OP_RCPA, OP_RCPB: kind_q <= K_DIV;
                        default:                 kind_q <= K_BAD;
                    endcase
                    x_q <= (OpCode == OP_RCPA || OpCode == OP_RCPB) ? ONE : A;
                    case (OpCode)
                        OP_SUB:  y_q <= {~B[WIDTH-1], B[WIDTH-2:0]};
                        OP_RCPA: y_q <= A;
                        default: y_q <= B;
                    endcase
                end
                ST_UNPACK: begin
                    cnt_q  <= '0;
                    prod_q <= NW'(my);
                    rem_q  <= {1'b0, mx};
                    quo_q  <= '0;
                    if (spec) begin
                        Result        <= spec_res;
                        Overflow_out  <= 1'b0;
                        Underflow_out <= 1'b0;
                        Invalid_out   <= spec_inv;
                    end
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q + CNTW'(1);
                    case (kind_q)
                        K_ADD: begin
                            val_q <= NW'(add_sum) << (NW - SW);
                            exp_q <= add_exp;
                            sgn_q <= add_sgn;
                        end
                        K_MUL: begin
                            prod_q <= prod_next;
                            val_q  <= prod_next;
                            exp_q  <= exs + eys - BIAS_S + EW'(1);
                            sgn_q  <= sx ^ sy;
                        end
                        default: begin
                            rem_q <= rem_next;
                            quo_q <= quo_next;
                            val_q <= NW'(quo_next) << (NW - QW);
                            exp_q <= exs - eys + BIAS_S;
                            sgn_q <= sx ^ sy;
                        end
                    endcase
                end
                ST_NORM: begin
                    Result        <= norm_res;
                    Overflow_out  <= norm_ovf;
                    Underflow_out <= norm_unf;
                    Invalid_out   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_seq.sv
// Directed-vector bench for fpu_seq: values, flags, latency, stall and reset behaviour.
module tb_fpu_seq;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIV = 3'b011;
    localparam logic [2:0] RCA = 3'b100, RCB = 3'b101, BAD = 3'b110;
    localparam logic [31:0] QNAN = 32'h7FC00000, PINF = 32'h7F800000;

    logic        clk, rst;
    logic [31:0] A, B, Result;
    logic [2:0]  OpCode;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        Overflow_out, Underflow_out, Invalid_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    logic seen;

    fpu_seq dut (
        .clk           (clk),
        .rst           (rst),
        .A             (A),
        .B             (B),
        .OpCode        (OpCode),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Result        (Result),
        .Overflow_out  (Overflow_out),
        .Underflow_out (Underflow_out),
        .Invalid_out   (Invalid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flags are {Overflow, Underflow, Invalid}; latency counts the UNPACK cycle as 1.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [2:0] exp_flg, input int exp_lat, input int hold);
        int c;
        c = 0;
        while (!in_ready && c < 50) begin @(negedge clk); c++; end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        A = a; B = b; OpCode = op; in_valid = 1'b1;
        @(negedge clk);
        A = $urandom; B = $urandom; OpCode = 3'($urandom);
        c = 1;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        while (!out_valid && c < 100) begin @(negedge clk); c++; end
        check({tag, "_lat"}, 32'(c), 32'(exp_lat));
        check({tag, "_res"}, Result, exp_res);
        check({tag, "_flg"}, 32'({Overflow_out, Underflow_out, Invalid_out}), 32'(exp_flg));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_res"}, Result, exp_res);
            check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; OpCode = '0;
        repeat (2) @(negedge clk);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_res", Result, 32'd0);
        check("rst_flg", 32'({Overflow_out, Underflow_out, Invalid_out}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_rdy", 32'(in_ready), 32'd1);

        run_op("add_2_3",    ADD, 32'h40000000, 32'h40400000, 32'h40A00000, 3'b000, 4, 0);
        run_op("sub_3_2",    SUB, 32'h40400000, 32'h40000000, 32'h3F800000, 3'b000, 4, 0);
        run_op("sub_exact0", SUB, 32'h40000000, 32'h40000000, 32'h00000000, 3'b000, 4, 0);
        run_op("add_trunc",  ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000, 4, 0);
        run_op("sub_tiny",   SUB, 32'h3F800000, 32'h33000000, 32'h3F7FFFFF, 3'b000, 4, 0);
        run_op("sub_sticky", SUB, 32'h3F800000, 32'h30800000, 32'h3F7FFFFF, 3'b000, 4, 0);
        run_op("add_ovf",    ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, PINF,         3'b100, 4, 0);
        run_op("sub_unf",    SUB, 32'h00800001, 32'h00800000, 32'h00000000, 3'b010, 4, 0);
        run_op("mul_2_3",    MUL, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 27, 0);
        run_op("mul_neg",    MUL, 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 27, 0);
        run_op("mul_15sq",   MUL, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 27, 10);
        run_op("mul_ovf",    MUL, 32'h7F000000, 32'h40000000, PINF,         3'b100, 27, 0);
        run_op("mul_unf",    MUL, 32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 27, 0);
        run_op("div_6_2",    DIV, 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 29, 0);
        run_op("rcpb_4",     RCB, 32'h12345678, 32'h40800000, 32'h3E800000, 3'b000, 29, 0);
        run_op("rcpa_3",     RCA, 32'h40400000, 32'h00000000, 32'h3EAAAAAA, 3'b000, 29, 0);
        run_op("div_by0",    DIV, 32'h40000000, 32'h00000000, PINF,         3'b000, 2, 0);
        run_op("inf_m_inf",  SUB, PINF,         PINF,         QNAN,         3'b001, 2, 0);
        run_op("zero_x_inf", MUL, 32'h00000000, PINF,         QNAN,         3'b001, 2, 0);
        run_op("div_00",     DIV, 32'h00000000, 32'h80000000, QNAN,         3'b001, 2, 0);
        run_op("div_infinf", DIV, PINF,         32'hFF800000, QNAN,         3'b001, 2, 0);
        run_op("fin_by_inf", DIV, 32'hBF800000, PINF,         32'h80000000, 3'b000, 2, 0);
        run_op("nan_in",     ADD, 32'h7FC00001, 32'h3F800000, QNAN,         3'b001, 2, 0);
        run_op("bad_op",     BAD, 32'h3F800000, 32'h3F800000, QNAN,         3'b001, 2, 0);
        run_op("inf_p_one",  ADD, PINF,         32'h3F800000, PINF,         3'b000, 2, 0);
        run_op("nz_p_pz",    ADD, 32'h80000000, 32'h00000000, 32'h00000000, 3'b000, 2, 0);
        run_op("subn_in",    ADD, 32'h00000001, 32'h3F800000, 32'h3F800000, 3'b000, 2, 0);

        // Reset while a result is on the output drops it asynchronously.
        A = 32'h40000000; B = 32'h40400000; OpCode = ADD; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
        check("done_seen", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("rstd_vld", 32'(out_valid), 32'd0);
        check("rstd_res", Result, 32'd0);
        check("rstd_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstd_rel_rdy", 32'(in_ready), 32'd1);

        // Reset in the middle of a divide aborts it with no response.
        A = 32'h40C00000; B = 32'h40000000; OpCode = DIV; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstx_vld", 32'(out_valid), 32'd0);
        check("rstx_rdy", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstx_rel_rdy", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rstx_no_resp", 32'(seen), 32'd0);
        run_op("mul_after_rst", MUL, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 27, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
